// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Chunk-serial subtractor: diff = (a - b - b_in) mod 2^WIDTH, computed
// CHUNK bits per cycle over N = WIDTH/CHUNK cycles with a registered borrow
// between chunks. Valid/ready handshake on both the operand and result side.
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed overflow
// output and its logic. Without the macro the port does not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (state IDLE)
//   a          in   minuend, WIDTH bits
//   b          in   subtrahend, WIDTH bits
//   b_in       in   borrow-in
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer accepts result
//   diff       out  (a - b - b_in) mod 2^WIDTH
//   b_out      out  final borrow, 1 iff a < b + b_in (unsigned)
//   overflow   out  signed overflow (SERIAL_SUB_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             last_chunk;
    logic             accept;

    logic [CHUNK:0]   step;
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_borrow;
    logic [WIDTH-1:0] diff_next;

    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (cnt == LAST);

    // One CHUNK-bit subtract cell, one bit wider so the top bit is the
    // borrow out: any negative result wraps into the upper half.
    assign step         = {1'b0, a_sh[CHUNK-1:0]}
                        - {1'b0, b_sh[CHUNK-1:0]}
                        - {{CHUNK{1'b0}}, borrow};
    assign chunk_diff   = step[CHUNK-1:0];
    assign chunk_borrow = step[CHUNK];

    // Result enters at the top and moves down, so after N steps the first
    // (least significant) chunk has reached bit 0.
    if (CHUNK == WIDTH) begin : g_full_chunk
        assign diff_next = chunk_diff;
    end else begin : g_part_chunk
        assign diff_next = {chunk_diff, diff[WIDTH-1:CHUNK]};
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ------------------------------------------------------------------
    // Operand shift registers
    // ------------------------------------------------------------------
    // NOTE: operand registers carry no reset; they are always loaded on
    // accept before being read, so reset would only cost area and routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == RUN) begin
            a_sh <= a_sh >> CHUNK;
            b_sh <= b_sh >> CHUNK;
        end
    end

    // ------------------------------------------------------------------
    // Borrow, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        borrow <= b_in;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    diff   <= diff_next;
                    borrow <= chunk_borrow;
                    cnt    <= cnt + 1'b1;
                    if (last_chunk) begin
                        b_out <= chunk_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Borrow into the MSB XOR borrow out of the MSB reduces to the sign-bit
    // form: operands differ in sign and the result's sign differs from a.
    // This avoids splitting the cell around the top bit.
    logic msb_overflow;

    assign msb_overflow = (a_sh[CHUNK-1] ^ b_sh[CHUNK-1])
                        & (chunk_diff[CHUNK-1] ^ a_sh[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (state == RUN && last_chunk) begin
            overflow <= msb_overflow;
        end
    end
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, chunk-serial subtractor: computes diff = a - b - b_in over WIDTH/CHUNK cycles, CHUNK bits per cycle, with one registered borrow between chunks.
- Borrow-propagate counterpart to the datapath's ripple-carry adder; trades latency for a CHUNK-bit-wide subtract cell.
- Valid/ready handshake on both input and output sides; sits between operand staging logic and a result consumer.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per RUN cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - b_in) mod 2^WIDTH.
- b_out  output  1  final borrow; 1 iff a < b + b_in, unsigned.
- overflow  output  1  signed overflow (present only with SERIAL_SUB_OVERFLOW_EN).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and rst.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - RUN: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state.
- Reset, sampled at a clk edge with rst = 1:
  - state goes to IDLE, chunk counter to 0, borrow register to 0.
  - diff = 0, b_out = 0, overflow = 0, out_valid = 0, in_ready = 1 from the next cycle.
  - Reset asserted in any state, including mid-RUN, aborts the operation. The partial result is discarded and no out_valid pulse is produced.
- Accept: at a clk edge with in_valid & in_ready:
  - latch a and b into operand shift registers;
  - borrow register <= b_in, counter <= 0, state -> RUN.
  - a, b and b_in are sampled only at this edge.
- RUN, each cycle:
  - subtract the low CHUNK bits of the operand registers with the current borrow.
  - Shift the CHUNK result bits into the top of the result register, LSB chunk first.
  - Shift the operand registers right by CHUNK, update the borrow register, and increment the counter.
- After N = WIDTH/CHUNK RUN cycles, state -> DONE, with b_out = final borrow and diff fully assembled.
- Latency: accept at edge k gives out_valid = 1 after edge k+N.
- DONE:
  - diff, b_out and overflow are held stable while out_ready = 0.
  - At an edge with out_ready = 1, state -> IDLE. The next accept can occur no earlier than the following edge, so throughput is one result per N+2 cycles minimum.
- in_valid during RUN or DONE is ignored; no data is lost or queued.
- diff, b_out and overflow keep their last values in IDLE; they are meaningful only while out_valid = 1.
- Width rule: no internal widening beyond CHUNK+1 bits per step. Wrap-around is modulo 2^WIDTH.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - overflow port present; computed as (borrow into the MSB) XOR (borrow out of the MSB), captured with the final chunk.
  - Held with diff; reset to 0.
- Undefined: no overflow port and no associated logic; all other behaviour identical.

Test Plan (WIDTH=8, CHUNK=2, N=4):
- a=0x5A, b=0x23, b_in=0 -> out_valid 4 cycles after accept; diff=0x37, b_out=0.
- a=0x10, b=0x20, b_in=0 -> diff=0xF0, b_out=1.
- a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1. Then a=0xFF, b=0xFF, b_in=0 -> diff=0x00, b_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; pulse in_valid with a=0x01, b=0x01 meanwhile -> in_ready=0, diff/b_out unchanged and the extra operands ignored; out_ready=1 -> IDLE next cycle.
- rst=1 during the 2nd RUN cycle of a=0x5A, b=0x23 -> no out_valid; next cycle in_ready=1, diff=0, b_out=0; a fresh a=0x09, b=0x03 yields diff=0x06.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1.
  - a=0x7F, b=0xFF -> diff=0x80, overflow=1.
  - a=0x05, b=0x03 -> overflow=0.
